// File: rtl/rr_sel_pkg.sv
// rtl/rr_sel_pkg.sv - shared constants and pointer helper for round-robin arbiters
package rr_sel_pkg;

  localparam int RR_N     = 4;
  localparam int RR_WIDTH = 8;

  // Wrap-increment of a requester index within 0..n-1.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx == n - 1) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin winner search starting at a pointer
module rr_pick import rr_sel_pkg::*; #(
  parameter int N     = RR_N,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     i_valid,
  input  logic [SEL_W-1:0] i_ptr,
  output logic [SEL_W-1:0] o_winner,
  output logic             o_any_valid
);

  logic [N-1:0]     w_rot;
  logic [SEL_W-1:0] w_off;
  logic [SEL_W:0]   w_sum;

  // Doubling the vector makes the wrap a plain right shift by ptr.
  assign w_rot = N'({i_valid, i_valid} >> i_ptr);

  always_comb begin
    w_off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = SEL_W'(i);
    end
    w_sum = {1'b0, i_ptr} + {1'b0, w_off};
    if (w_sum >= (SEL_W + 1)'(N)) w_sum = w_sum - (SEL_W + 1)'(N);
  end

  assign o_winner    = w_sum[SEL_W-1:0];
  assign o_any_valid = |i_valid;

endmodule

// File: rtl/rr_sel_arbiter.sv
// rtl/rr_sel_arbiter.sv - round-robin arbiter with registered data/select output stage
module rr_sel_arbiter import rr_sel_pkg::*; #(
  parameter int  N     = RR_N,
  parameter int  WIDTH = RR_WIDTH,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  input  logic               out_ready
);

  logic [SEL_W-1:0] r_ptr;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_sel;

  logic [SEL_W-1:0] w_winner;
  logic             w_any;
  logic             w_load;
  logic [WIDTH-1:0] w_words [N];

  rr_pick #(.N(N), .SEL_W(SEL_W)) u_pick (
    .i_valid     (in_valid),
    .i_ptr       (r_ptr),
    .o_winner    (w_winner),
    .o_any_valid (w_any)
  );

  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_words[i] = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Refill whenever the stage is empty or being drained this cycle.
  assign w_load   = (!r_out_valid || out_ready) && w_any;
  assign in_ready = w_load ? (N'(1) << w_winner) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
    end else if (w_load) begin
      r_out_data  <= w_words[w_winner];
      r_out_sel   <= w_winner;
      r_out_valid <= 1'b1;
      r_ptr       <= SEL_W'(rr_next(32'(w_winner), N));
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// tb/tb_rr_sel_arbiter.sv - table, corner-sequence and random checks for rr_sel_arbiter (N=4 and N=3)
module tb_rr_sel_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic [3:0]  in_ready4;
  logic        out_valid4;
  logic [7:0]  out_data4;
  logic [1:0]  out_sel4;

  logic [2:0]  in_ready3;
  logic        out_valid3;
  logic [7:0]  out_data3;
  logic [1:0]  out_sel3;

  int pass_cnt = 0;
  int total_cnt = 0;

  rr_sel_arbiter #(.N(4), .WIDTH(8)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready4),
    .out_valid (out_valid4),
    .out_data  (out_data4),
    .out_sel   (out_sel4),
    .out_ready (out_ready)
  );

  rr_sel_arbiter #(.N(3), .WIDTH(8)) u_dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid[2:0]),
    .in_data   (in_data[23:0]),
    .in_ready  (in_ready3),
    .out_valid (out_valid3),
    .out_data  (out_data3),
    .out_sel   (out_sel3),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  // Reference model: index 0 models N=4, index 1 models N=3.
  int         m_ptr [2];
  logic       m_ov  [2];
  logic [1:0] m_sel [2];
  logic [7:0] m_od  [2];

  function automatic int nreq(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  function automatic int pick(input logic [3:0] v, input int p, input int n);
    for (int k = 0; k < n; k++) begin
      if (v[(p + k) % n]) return (p + k) % n;
    end
    return -1;
  endfunction

  function automatic logic [3:0] vmask(input int d);
    return (d == 0) ? in_valid : (in_valid & 4'b0111);
  endfunction

  task automatic model_check();
    for (int d = 0; d < 2; d++) begin
      int w;
      logic ld;
      logic [3:0] exp_ir;
      w = pick(vmask(d), m_ptr[d], nreq(d));
      ld = (!m_ov[d] || out_ready) && (w >= 0);
      exp_ir = ld ? (4'b0001 << w) : 4'b0000;
      if (d == 0) begin
        chk("model4 in_ready",  {28'd0, in_ready4},  {28'd0, exp_ir});
        chk("model4 out_valid", {31'd0, out_valid4}, {31'd0, m_ov[0]});
        chk("model4 out_sel",   {30'd0, out_sel4},   {30'd0, m_sel[0]});
        chk("model4 out_data",  {24'd0, out_data4},  {24'd0, m_od[0]});
      end else begin
        chk("model3 in_ready",  {29'd0, in_ready3},  {28'd0, exp_ir});
        chk("model3 out_valid", {31'd0, out_valid3}, {31'd0, m_ov[1]});
        chk("model3 out_sel",   {30'd0, out_sel3},   {30'd0, m_sel[1]});
        chk("model3 out_data",  {24'd0, out_data3},  {24'd0, m_od[1]});
      end
    end
  endtask

  task automatic model_update();
    for (int d = 0; d < 2; d++) begin
      int w;
      w = pick(vmask(d), m_ptr[d], nreq(d));
      if (!rst_n) begin
        m_ptr[d] = 0; m_ov[d] = 1'b0; m_sel[d] = 2'd0; m_od[d] = 8'h00;
      end else if ((!m_ov[d] || out_ready) && (w >= 0)) begin
        m_od[d]  = in_data[w*8 +: 8];
        m_sel[d] = w[1:0];
        m_ov[d]  = 1'b1;
        m_ptr[d] = (w + 1) % nreq(d);
      end else if (out_ready) begin
        m_ov[d] = 1'b0;
      end
    end
  endtask

  task automatic apply(input logic r, input logic [3:0] iv, input logic ordy, input logic [31:0] d);
    @(negedge clk);
    rst_n = r; in_valid = iv; out_ready = ordy; in_data = d;
    #1;
    model_check();
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_update();
  endtask

  typedef struct {
    logic        rst_n;
    logic [3:0]  iv;
    logic        ordy;
    logic [31:0] data;
    logic [3:0]  ir;
    logic        ov;
    logic [1:0]  sel;
    logic [7:0]  od;
  } vec_t;

  localparam logic [31:0] D = 32'hA3A2A1A0;
  localparam logic [31:0] E = 32'h55A2A1A0;

  vec_t vecs [23];

  initial begin
    vecs[0]  = '{1'b1, 4'b0000, 1'b1, D, 4'b0000, 1'b0, 2'd0, 8'h00};
    vecs[1]  = '{1'b1, 4'b1111, 1'b1, D, 4'b0001, 1'b0, 2'd0, 8'h00};
    vecs[2]  = '{1'b1, 4'b1111, 1'b1, D, 4'b0010, 1'b1, 2'd0, 8'hA0};
    vecs[3]  = '{1'b1, 4'b1111, 1'b1, D, 4'b0100, 1'b1, 2'd1, 8'hA1};
    vecs[4]  = '{1'b1, 4'b1111, 1'b1, D, 4'b1000, 1'b1, 2'd2, 8'hA2};
    vecs[5]  = '{1'b1, 4'b1111, 1'b1, D, 4'b0001, 1'b1, 2'd3, 8'hA3};
    vecs[6]  = '{1'b1, 4'b0000, 1'b1, D, 4'b0000, 1'b1, 2'd0, 8'hA0};
    vecs[7]  = '{1'b0, 4'b0000, 1'b1, D, 4'b0000, 1'b0, 2'd0, 8'hA0};
    vecs[8]  = '{1'b1, 4'b0011, 1'b1, D, 4'b0001, 1'b0, 2'd0, 8'h00};
    vecs[9]  = '{1'b1, 4'b0010, 1'b1, D, 4'b0010, 1'b1, 2'd0, 8'hA0};
    vecs[10] = '{1'b1, 4'b0011, 1'b1, D, 4'b0001, 1'b1, 2'd1, 8'hA1};
    vecs[11] = '{1'b1, 4'b0011, 1'b1, D, 4'b0010, 1'b1, 2'd0, 8'hA0};
    vecs[12] = '{1'b1, 4'b0000, 1'b1, D, 4'b0000, 1'b1, 2'd1, 8'hA1};
    vecs[13] = '{1'b1, 4'b1000, 1'b1, E, 4'b1000, 1'b0, 2'd1, 8'hA1};
    vecs[14] = '{1'b1, 4'b0001, 1'b0, E, 4'b0000, 1'b1, 2'd3, 8'h55};
    vecs[15] = '{1'b1, 4'b0001, 1'b0, E, 4'b0000, 1'b1, 2'd3, 8'h55};
    vecs[16] = '{1'b1, 4'b0001, 1'b0, E, 4'b0000, 1'b1, 2'd3, 8'h55};
    vecs[17] = '{1'b1, 4'b0001, 1'b1, E, 4'b0001, 1'b1, 2'd3, 8'h55};
    vecs[18] = '{1'b1, 4'b0000, 1'b0, E, 4'b0000, 1'b1, 2'd0, 8'hA0};
    vecs[19] = '{1'b0, 4'b0000, 1'b0, E, 4'b0000, 1'b1, 2'd0, 8'hA0};
    vecs[20] = '{1'b1, 4'b1010, 1'b0, D, 4'b0010, 1'b0, 2'd0, 8'h00};
    vecs[21] = '{1'b1, 4'b0000, 1'b1, D, 4'b0000, 1'b1, 2'd1, 8'hA1};
    vecs[22] = '{1'b1, 4'b0000, 1'b0, D, 4'b0000, 1'b0, 2'd1, 8'hA1};

    rst_n = 1'b0; in_valid = 4'b0000; out_ready = 1'b0; in_data = 32'd0;
    for (int d = 0; d < 2; d++) begin
      m_ptr[d] = 0; m_ov[d] = 1'b0; m_sel[d] = 2'd0; m_od[d] = 8'h00;
    end
    repeat (2) @(posedge clk);

    for (int i = 0; i < 23; i++) begin
      apply(vecs[i].rst_n, vecs[i].iv, vecs[i].ordy, vecs[i].data);
      chk($sformatf("vec%0d in_ready", i),  {28'd0, in_ready4},  {28'd0, vecs[i].ir});
      chk($sformatf("vec%0d out_valid", i), {31'd0, out_valid4}, {31'd0, vecs[i].ov});
      chk($sformatf("vec%0d out_sel", i),   {30'd0, out_sel4},   {30'd0, vecs[i].sel});
      chk($sformatf("vec%0d out_data", i),  {24'd0, out_data4},  {24'd0, vecs[i].od});
      edge_step();
    end

    // N=3: grant the last requester, then the pointer must wrap to 0.
    apply(1'b0, 4'b0000, 1'b0, D); edge_step();
    apply(1'b1, 4'b0100, 1'b1, D);
    chk("n3 grant2 in_ready", {29'd0, in_ready3}, 32'd4);
    edge_step();
    apply(1'b1, 4'b0111, 1'b1, D);
    chk("n3 wrap in_ready", {29'd0, in_ready3}, 32'd1);
    chk("n3 sel2",          {30'd0, out_sel3},  32'd2);
    chk("n3 data2",         {24'd0, out_data3}, 32'hA2);
    edge_step();
    apply(1'b1, 4'b0000, 1'b1, D);
    chk("n3 sel0",   {30'd0, out_sel3},   32'd0);
    chk("n3 data0",  {24'd0, out_data3},  32'hA0);
    chk("n3 valid1", {31'd0, out_valid3}, 32'd1);
    edge_step();
    apply(1'b1, 4'b0000, 1'b0, D);
    chk("n3 drained", {31'd0, out_valid3}, 32'd0);
    edge_step();

    for (int c = 0; c < 400; c++) begin
      logic r;
      r = ($urandom_range(0, 39) != 0);
      apply(r, r ? 4'($urandom_range(0, 15)) : 4'b0000, ($urandom_range(0, 3) != 0), $urandom);
      edge_step();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
